axi4_slave_port_arbiter: RTL and testbench

- Per-slave, per-address-channel arbiter for the AXI4 interconnect. Instantiated once for AW and once for AR on every slave port.
- Takes the decoded, permission-checked requests from all masters targeting this slave and grants one master at a time, round-robin.
- Holds ownership until that master's outstanding transactions drain. This guarantees in-order, single-owner response routing without ID remapping.
- Grant outputs drive the interconnect address/response muxes.

---
 rtl/axi4_ic_pkg.sv | 38 +++
 rtl/axi4_rr_pick.sv | 32 +++
 rtl/axi4_slave_port_arbiter.sv | 129 ++++++++++++
 tb/tb_axi4_slave_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_ic_pkg.sv
// Shared definitions for the AXI4 interconnect arbitration logic:
// arbiter state encoding, default limits and the round-robin search.
package axi4_ic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_t;

   localparam int DEF_NUM_MASTERS     = 8;
   localparam int DEF_MAX_OUTSTANDING = 4;
   localparam int DEF_MAX_CONSEC      = 8;

   // Widest request vector the search function handles.
   localparam int RR_MAX_W = 32;

   // Index of the first set bit of req[n-1:0], scanning upward from ptr
   // with wrap; -1 when no bit is set. The scan runs from the largest
   // offset down so the smallest offset from ptr is the one that sticks.
   function automatic int rr_first_set(input logic [RR_MAX_W-1:0] req,
                                       input int n,
                                       input int ptr);
      int                  idx;
      logic [RR_MAX_W-1:0] sh;
      rr_first_set = -1;
      for (int k = RR_MAX_W - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            sh = req >> idx;
            if (sh[0]) rr_first_set = idx;
         end
      end
   endfunction

endpackage

// File: rtl/axi4_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr
// (with wrap), reported as one-hot, binary index and an any flag.
module axi4_rr_pick
   import axi4_ic_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index,
   output logic          any
);

   // Search from the pointer and encode the winner.
   always_comb begin
      logic [RR_MAX_W-1:0] req_ext;
      int                  w;
      req_ext        = '0;
      req_ext[N-1:0] = req;
      w              = rr_first_set(req_ext, N, int'(ptr));
      any            = (w >= 0);
      onehot         = '0;
      index          = '0;
      if (w >= 0) begin
         onehot = N'(1) << w;
         index  = IW'(w);
      end
   end

endmodule

// File: rtl/axi4_slave_port_arbiter.sv
// Per-slave, per-address-channel round-robin arbiter. One master owns the
// slave at a time and keeps it until its outstanding transactions drain,
// so responses route to a single owner in order without ID remapping.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; pick the next requester round-robin
//   ST_ADDR  | owner's address forwarded (grant_valid=1), wait s_ready
//   ST_HOLD  | owner kept, no address forwarded; decide reissue or drain
//   ST_DRAIN | no new addresses; wait for outstanding to reach zero
module axi4_slave_port_arbiter
   import axi4_ic_pkg::*;
#(
   parameter int NUM_MASTERS     = DEF_NUM_MASTERS,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int MAX_CONSEC      = DEF_MAX_CONSEC,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
   parameter int ID_W            = $clog2(NUM_MASTERS)
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   s_ready,
   input  logic                   resp_done,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [ID_W-1:0]        grant_id,
   output logic                   grant_valid,
   output logic [CNT_W-1:0]       outstanding,
   output logic                   err_underflow
);

   localparam int CONSEC_W = $clog2(MAX_CONSEC + 1);

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [ID_W-1:0]        ptr;
   logic [CONSEC_W-1:0]    consec;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [ID_W-1:0]        pick_index;
   logic                   pick_any;
   logic                   handshake;
   logic                   owner_req;
   logic                   rival_req;
   logic                   below_limit;
   logic                   under_consec;
   logic                   reissue;

   axi4_rr_pick #(
      .N  (NUM_MASTERS),
      .IW (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .index  (pick_index),
      .any    (pick_any)
   );

   assign owner_req    = |(req & grant);
   assign rival_req    = |(req & ~grant);
   assign below_limit  = outstanding < CNT_W'(MAX_OUTSTANDING);
   assign under_consec = consec < CONSEC_W'(MAX_CONSEC);
   // A waiting rival only cuts the owner off once it has used its burst.
   assign reissue      = owner_req && below_limit && (!rival_req || under_consec);

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decision.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pick_any) state_nxt = ST_ADDR;
         ST_ADDR:  if (s_ready)  state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (reissue)                     state_nxt = ST_ADDR;
            else if (rival_req || !owner_req) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (outstanding == '0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      grant_valid = (state == ST_ADDR);
      handshake   = grant_valid && s_ready;
   end

   // Owner and round-robin pointer: loaded on arbitration, owner cleared on drain exit.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grant    <= '0;
         grant_id <= '0;
         ptr      <= '0;
      end else if (state == ST_IDLE && pick_any) begin
         grant    <= pick_onehot;
         grant_id <= pick_index;
         ptr      <= (pick_index == ID_W'(NUM_MASTERS - 1)) ? '0 : pick_index + 1'b1;
      end else if (state == ST_DRAIN && state_nxt == ST_IDLE) begin
         grant    <= '0;
         grant_id <= '0;
      end
   end

   // Outstanding count; a response with nothing outstanding flags a sticky error.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         outstanding   <= '0;
         err_underflow <= 1'b0;
      end else if (handshake && !resp_done) begin
         outstanding <= outstanding + 1'b1;
      end else if (!handshake && resp_done) begin
         if (outstanding == '0) err_underflow <= 1'b1;
         else                   outstanding   <= outstanding - 1'b1;
      end
   end

   // Handshakes in the current tenure, saturating; restarts with each owner.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                      consec <= '0;
      else if (state == ST_IDLE)         consec <= '0;
      else if (handshake && under_consec) consec <= consec + 1'b1;
   end

endmodule

// File: tb/tb_axi4_slave_port_arbiter.sv
// Directed bench for axi4_slave_port_arbiter with a tenure-level model.
module tb_axi4_slave_port_arbiter;

   localparam int N       = 8;
   localparam int MAX_OUT = 4;
   localparam int MAX_CON = 8;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic [N-1:0] req;
   logic         s_ready;
   logic         resp_done;
   logic [N-1:0] grant;
   logic [2:0]   grant_id;
   logic         grant_valid;
   logic [2:0]   outstanding;
   logic         err_underflow;

   axi4_slave_port_arbiter dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .req           (req),
      .s_ready       (s_ready),
      .resp_done     (resp_done),
      .grant         (grant),
      .grant_id      (grant_id),
      .grant_valid   (grant_valid),
      .outstanding   (outstanding),
      .err_underflow (err_underflow)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   bit auto_resp = 1'b0;

   // Model: who owns the slave, whether its address is on offer, whether it
   // is winding down, how many transactions are in flight.
   int m_owner = -1;
   int m_next = 0;
   int m_inflight = 0;
   int m_tenure_hs = 0;
   bit m_addr_live = 1'b0;
   bit m_closing = 1'b0;
   bit m_err = 1'b0;
   int q_owner[$];
   int q_hs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner     = -1;
      m_next      = 0;
      m_inflight  = 0;
      m_tenure_hs = 0;
      m_addr_live = 1'b0;
      m_closing   = 1'b0;
      m_err       = 1'b0;
   endtask

   task automatic model_step();
      int           old_n;
      int           win;
      int           idx;
      bit           hs;
      bit           mine;
      bit           rivals;
      logic [N-1:0] own_mask;
      logic [N-1:0] sh;
      if (!aresetn) begin
         model_reset();
         return;
      end
      old_n = m_inflight;
      hs    = m_addr_live && s_ready;
      if (hs && resp_done) begin
      end else if (hs) begin
         m_inflight++;
      end else if (resp_done) begin
         if (m_inflight == 0) m_err = 1'b1;
         else                 m_inflight--;
      end
      if (m_owner < 0) begin
         win = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_next + k) % N;
            sh  = req >> idx;
            if (win < 0 && sh[0]) win = idx;
         end
         if (win >= 0) begin
            m_owner     = win;
            m_next      = (win + 1) % N;
            m_addr_live = 1'b1;
            m_closing   = 1'b0;
            m_tenure_hs = 0;
            q_owner.push_back(win);
         end
      end else if (m_addr_live) begin
         if (s_ready) begin
            m_addr_live = 1'b0;
            m_tenure_hs++;
         end
      end else if (m_closing) begin
         if (old_n == 0) begin
            q_hs.push_back(m_tenure_hs);
            m_owner   = -1;
            m_closing = 1'b0;
         end
      end else begin
         own_mask = N'(1) << m_owner;
         mine     = (req & own_mask) != '0;
         rivals   = (req & ~own_mask) != '0;
         if (mine && old_n < MAX_OUT && (!rivals || m_tenure_hs < MAX_CON)) m_addr_live = 1'b1;
         else if (rivals || !mine) m_closing = 1'b1;
      end
   endtask

   task automatic compare_model();
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("cyc_grant",       32'(grant),         32'(eg));
      check("cyc_grant_id",    32'(grant_id),      (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("cyc_grant_valid", 32'(grant_valid),   32'(m_addr_live));
      check("cyc_outstanding", 32'(outstanding),   32'(m_inflight));
      check("cyc_err",         32'(err_underflow), 32'(m_err));
      check("cyc_onehot0",     32'($onehot0(grant)), 32'd1);
      check("cyc_valid_owner", 32'(grant_valid && grant == '0), 32'd0);
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge aclk);
         compare_model();
         @(posedge aclk);
         model_step();
         #1;
         if (auto_resp) resp_done = (m_inflight > 0) && !m_addr_live;
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      model_reset();
      cyc(2);
      aresetn = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while (!(grant == '0 && outstanding == '0 && m_owner < 0) && c < 100) begin
         cyc(1);
         c++;
      end
      check(name, 32'(c < 100), 32'd1);
   endtask

   int exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

   initial begin
      int obase;
      int hbase;
      int v;
      req = '0; s_ready = 1'b0; resp_done = 1'b0;
      do_reset();
      check("reset_grant",   32'(grant),         32'd0);
      check("reset_gid",     32'(grant_id),      32'd0);
      check("reset_gvalid",  32'(grant_valid),   32'd0);
      check("reset_out",     32'(outstanding),   32'd0);
      check("reset_err",     32'(err_underflow), 32'd0);

      // Single master, single transaction.
      req = 8'h01; s_ready = 1'b1;
      cyc(1);
      check("t1_grant",  32'(grant),       32'h01);
      check("t1_gvalid", 32'(grant_valid), 32'd1);
      cyc(1);
      check("t1_gvalid_drop", 32'(grant_valid), 32'd0);
      check("t1_out",         32'(outstanding), 32'd1);
      req = '0;
      cyc(1);
      resp_done = 1'b1; cyc(1); resp_done = 1'b0;
      check("t1_out0",       32'(outstanding), 32'd0);
      check("t1_still_own",  32'(grant),       32'h01);
      cyc(1);
      check("t1_released",   32'(grant),       32'd0);

      // All masters requesting: strict rotation, 8 handshakes per tenure.
      do_reset();
      obase = q_owner.size();
      hbase = q_hs.size();
      req = 8'hFF; s_ready = 1'b1; auto_resp = 1'b1;
      for (int c = 0; c < 400 && q_owner.size() < obase + 9; c++) cyc(1);
      check("t2_tenures", 32'(q_owner.size() >= obase + 9), 32'd1);
      for (int i = 0; i < 9; i++) begin
         v = (obase + i < q_owner.size()) ? q_owner[obase + i] : -1;
         check("t2_order", 32'(v), 32'(exp_order[i]));
      end
      for (int i = 0; i < 8; i++) begin
         v = (hbase + i < q_hs.size()) ? q_hs[hbase + i] : -1;
         check("t2_burst", 32'(v), 32'd8);
      end
      req = '0;
      wait_idle("t2_idle");
      auto_resp = 1'b0; resp_done = 1'b0;
      check("t2_no_err", 32'(err_underflow), 32'd0);

      // Master 3 streaming with responses withheld: stops at the limit.
      req = 8'h08; s_ready = 1'b1;
      cyc(12);
      check("t3_out_limit", 32'(outstanding), 32'd4);
      check("t3_gvalid",    32'(grant_valid), 32'd0);
      check("t3_grant",     32'(grant),       32'h08);
      check("t3_model_hs",  32'(m_tenure_hs), 32'd4);
      resp_done = 1'b1; cyc(1); resp_done = 1'b0;
      check("t3_out3", 32'(outstanding), 32'd3);
      cyc(1);
      check("t3_reissue", 32'(grant_valid), 32'd1);
      cyc(1);
      check("t3_out4_again", 32'(outstanding), 32'd4);
      check("t3_model_hs5",  32'(m_tenure_hs), 32'd5);
      req = '0; auto_resp = 1'b1;
      wait_idle("t3_idle");
      auto_resp = 1'b0; resp_done = 1'b0;

      // Owner 2 with two outstanding, master 5 takes over after drain.
      req = 8'h04; s_ready = 1'b1;
      cyc(4);
      check("t4_out2",  32'(outstanding), 32'd2);
      check("t4_grant", 32'(grant),       32'h04);
      req = 8'h20;
      cyc(4);
      check("t4_drain_gvalid", 32'(grant_valid), 32'd0);
      check("t4_drain_grant",  32'(grant),       32'h04);
      resp_done = 1'b1; cyc(2); resp_done = 1'b0;
      check("t4_drained", 32'(outstanding), 32'd0);
      cyc(1);
      check("t4_bubble", 32'(grant), 32'd0);
      cyc(1);
      check("t4_new_grant", 32'(grant),    32'h20);
      check("t4_new_gid",   32'(grant_id), 32'd5);

      // Handshake and response together, then an underflow.
      cyc(1);
      cyc(1);
      check("t5_in_addr", 32'(grant_valid), 32'd1);
      check("t5_out1",    32'(outstanding), 32'd1);
      resp_done = 1'b1; cyc(1); resp_done = 1'b0;
      check("t5_same_cycle", 32'(outstanding), 32'd1);
      req = '0;
      cyc(1);
      resp_done = 1'b1; cyc(1); resp_done = 1'b0;
      cyc(1);
      check("t5_idle",   32'(grant),         32'd0);
      check("t5_no_err", 32'(err_underflow), 32'd0);
      resp_done = 1'b1; cyc(1); resp_done = 1'b0;
      check("t5_underflow", 32'(err_underflow), 32'd1);
      check("t5_out_zero",  32'(outstanding),   32'd0);
      cyc(3);
      check("t5_sticky", 32'(err_underflow), 32'd1);

      // Reset in the middle of an address phase.
      req = 8'h40; s_ready = 1'b1;
      cyc(7);
      check("t6_out3",   32'(outstanding), 32'd3);
      check("t6_gvalid", 32'(grant_valid), 32'd1);
      check("t6_grant",  32'(grant),       32'h40);
      aresetn = 1'b0;
      model_reset();
      #1;
      check("t6_rst_grant",  32'(grant),         32'd0);
      check("t6_rst_gid",    32'(grant_id),      32'd0);
      check("t6_rst_gvalid", 32'(grant_valid),   32'd0);
      check("t6_rst_out",    32'(outstanding),   32'd0);
      check("t6_rst_err",    32'(err_underflow), 32'd0);
      cyc(2);
      aresetn = 1'b1;
      req = 8'h81;
      cyc(1);
      check("t6_ptr_restart", 32'(grant), 32'h01);
      req = '0; auto_resp = 1'b1;
      wait_idle("t6_idle");
      auto_resp = 1'b0; resp_done = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
